// File: rtl/shiftleds_pkg.sv
// Shared encodings for the shift-LED control path: owner codes and
// control-word field positions.
package shiftleds_pkg;

    localparam int NB_SW  = 4;
    localparam int NB_SEL = 2;

    localparam int SW_EN      = 0;
    localparam int SW_SEL_LSB = 1;
    localparam int SW_COLOR   = 3;

    typedef enum logic [1:0] {
        OWN_MANUAL = 2'd0,
        OWN_VIO    = 2'd1,
        OWN_AUTO   = 2'd2
    } owner_e;

endpackage

// File: rtl/shiftleds_auto_step.sv
// Autoplay scheduler: counts shift ticks, ping-pongs the limit selector and
// toggles color once per full sweep back to sel 0.
module shiftleds_auto_step #(
    parameter int NB_SEL          = 2,
    parameter int SHIFTS_PER_STEP = 8,
    parameter int NB_STEP_CNT     = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_init,
    input  logic              i_tick,
    output logic [NB_SEL-1:0] o_sel,
    output logic              o_color,
    output logic              o_sweep_done
);
    import shiftleds_pkg::*;

    localparam logic [NB_STEP_CNT-1:0] CNT_LAST = NB_STEP_CNT'(SHIFTS_PER_STEP - 1);
    localparam logic [NB_SEL-1:0]      SEL_MAX  = '1;

    logic [NB_STEP_CNT-1:0] cnt_q, cnt_d;
    logic [NB_SEL-1:0]      sel_q, sel_d;
    logic                   dir_down_q, dir_down_d;
    logic                   color_q, color_d;
    logic                   sweep_d;

    always_comb begin
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        dir_down_d = dir_down_q;
        color_d    = color_q;
        sweep_d    = 1'b0;
        if (i_init) begin
            cnt_d      = '0;
            sel_d      = '0;
            dir_down_d = 1'b0;
            color_d    = 1'b0;
        end else if (i_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (!dir_down_q) begin
                    sel_d = sel_q + NB_SEL'(1);
                    if (sel_d == SEL_MAX) dir_down_d = 1'b1;
                end else begin
                    sel_d = sel_q - NB_SEL'(1);
                    if (sel_d == '0) begin
                        dir_down_d = 1'b0;
                        color_d    = ~color_q;
                        sweep_d    = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + NB_STEP_CNT'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            cnt_q      <= '0;
            sel_q      <= '0;
            dir_down_q <= 1'b0;
            color_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            dir_down_q <= dir_down_d;
            color_q    <= color_d;
        end
    end

    // Next-state view so the parent's output register lines up with the step.
    assign o_sel        = sel_d;
    assign o_color      = color_d;
    assign o_sweep_done = sweep_d;

endmodule

// File: rtl/shiftleds_seq_ctrl.sv
// Control-word arbiter for the shift-LED datapath: picks MANUAL/VIO/AUTO and
// only swaps owner when the datapath is stopped or on a shift tick.
module shiftleds_seq_ctrl #(
    parameter int NB_SW           = 4,
    parameter int NB_SEL          = 2,
    parameter int SHIFTS_PER_STEP = 8,
    parameter int NB_STEP_CNT     = 8
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    input  logic             i_vio_req,
    input  logic [NB_SW-1:0] i_vio_sw,
    input  logic             i_auto,
    input  logic             i_shift_tick,
    output logic [NB_SW-1:0] o_sw,
    output logic [1:0]       o_owner,
    output logic             o_pending,
    output logic             o_sweep_done
);
    import shiftleds_pkg::*;

    owner_e             owner_q, owner_d, desired;
    logic [NB_SW-1:0]   sw_q, sw_d, auto_sw;
    logic               pend_q, pend_d;
    logic               done_q, done_d;
    logic               change, commit, auto_init, auto_tick;
    logic [NB_SEL-1:0]  auto_sel;
    logic               auto_color, auto_done;

    always_comb begin
        desired = OWN_MANUAL;
        if (i_vio_req)   desired = OWN_VIO;
        else if (i_auto) desired = OWN_AUTO;
    end

    assign change    = (desired != owner_q);
    assign commit    = change && (!sw_q[SW_EN] || i_shift_tick);
    assign auto_init = commit && (desired == OWN_AUTO);
    // A handover out of AUTO consumes the tick; no step is taken.
    assign auto_tick = i_shift_tick && (owner_q == OWN_AUTO) && !commit;

    shiftleds_auto_step #(
        .NB_SEL          (NB_SEL),
        .SHIFTS_PER_STEP (SHIFTS_PER_STEP),
        .NB_STEP_CNT     (NB_STEP_CNT)
    ) u_auto_step (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_init       (auto_init),
        .i_tick       (auto_tick),
        .o_sel        (auto_sel),
        .o_color      (auto_color),
        .o_sweep_done (auto_done)
    );

    always_comb begin
        auto_sw                         = '0;
        auto_sw[SW_EN]                  = 1'b1;
        auto_sw[SW_SEL_LSB +: NB_SEL]   = auto_sel;
        auto_sw[SW_COLOR]               = auto_color;
    end

    always_comb begin
        owner_d = commit ? desired : owner_q;
        pend_d  = change && !commit;
        done_d  = auto_done;
        sw_d    = sw_q;
        if (!pend_d) begin
            case (owner_d)
                OWN_VIO:  sw_d = i_vio_sw;
                OWN_AUTO: sw_d = auto_sw;
                default:  sw_d = i_sw;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            owner_q <= OWN_MANUAL;
            sw_q    <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            sw_q    <= sw_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign o_sw         = sw_q;
    assign o_owner      = owner_q;
    assign o_pending    = pend_q;
    assign o_sweep_done = done_q;

endmodule

// File: tb/tb_shiftleds_seq_ctrl.sv
// Bench for shiftleds_seq_ctrl: directed scenarios plus random traffic, every
// cycle compared against a sweep-table reference model.
module tb_shiftleds_seq_ctrl;

    localparam int SPS = 2;

    logic       clock = 1'b0;
    logic       i_reset, i_vio_req, i_auto, i_shift_tick;
    logic [3:0] i_sw, i_vio_sw;
    logic [3:0] o_sw;
    logic [1:0] o_owner;
    logic       o_pending, o_sweep_done;

    always #5 clock = ~clock;

    shiftleds_seq_ctrl #(
        .NB_SW(4), .NB_SEL(2), .SHIFTS_PER_STEP(SPS), .NB_STEP_CNT(8)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_sw         (i_sw),
        .i_vio_req    (i_vio_req),
        .i_vio_sw     (i_vio_sw),
        .i_auto       (i_auto),
        .i_shift_tick (i_shift_tick),
        .o_sw         (o_sw),
        .o_owner      (o_owner),
        .o_pending    (o_pending),
        .o_sweep_done (o_sweep_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a sweep is a walk through a 6-entry sel table.
    int         sel_tab [6] = '{0, 1, 2, 3, 2, 1};
    int         m_owner, m_cnt, m_pos;
    bit         m_pend, m_done, m_color;
    logic [3:0] m_sw;

    function automatic logic [3:0] src(input int own);
        case (own)
            1:       return i_vio_sw;
            2:       return {m_color, 2'(sel_tab[m_pos]), 1'b1};
            default: return i_sw;
        endcase
    endfunction

    task automatic model_step();
        int desired;
        if (!i_reset) begin
            m_owner = 0; m_sw = 4'h0; m_pend = 0; m_done = 0;
            m_cnt = 0; m_pos = 0; m_color = 0;
            return;
        end
        desired = i_vio_req ? 1 : (i_auto ? 2 : 0);
        m_done  = 0;
        if (desired != m_owner) begin
            if (m_sw[0] == 1'b0 || i_shift_tick) begin
                m_owner = desired;
                m_pend  = 0;
                if (desired == 2) begin
                    m_cnt = 0; m_pos = 0; m_color = 0;
                end
                m_sw = src(m_owner);
            end else begin
                m_pend = 1;
            end
        end else begin
            m_pend = 0;
            if (m_owner == 2 && i_shift_tick) begin
                m_cnt++;
                if (m_cnt == SPS) begin
                    m_cnt = 0;
                    m_pos = (m_pos + 1) % 6;
                    if (m_pos == 0) begin
                        m_color = !m_color;
                        m_done  = 1;
                    end
                end
            end
            m_sw = src(m_owner);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("sw", o_sw, m_sw);
        chk("owner", o_owner, m_owner);
        chk("pending", o_pending, m_pend);
        chk("sweep_done", o_sweep_done, m_done);
    endtask

    initial begin
        i_reset = 0; i_sw = 4'hF; i_vio_req = 0; i_vio_sw = 4'h0;
        i_auto = 0; i_shift_tick = 0;

        // Reset holds outputs at zero, release passes switches through.
        cycle(); cycle();
        chk("rst_sw", o_sw, 4'h0);
        chk("rst_owner", o_owner, 0);
        i_reset = 1;
        cycle();
        chk("rel_sw", o_sw, 4'hF);

        // Running manual: VIO request waits for a tick.
        i_sw = 4'b0001; cycle();
        i_vio_sw = 4'hA; i_vio_req = 1;
        repeat (5) begin
            cycle();
            chk("t2_pend", o_pending, 1);
            chk("t2_hold", o_sw, 4'b0001);
        end
        i_shift_tick = 1; cycle(); i_shift_tick = 0;
        chk("t2_owner", o_owner, 1);
        chk("t2_sw", o_sw, 4'hA);
        chk("t2_pend_clr", o_pending, 0);

        // Stopped manual: immediate handover.
        i_vio_req = 0; cycle();
        i_sw = 4'b0110; cycle();
        i_vio_req = 1; cycle();
        chk("t3_owner", o_owner, 1);
        chk("t3_pend", o_pending, 0);

        // Autoplay full sweep.
        i_vio_req = 0; i_sw = 4'h0; cycle(); cycle();
        i_auto = 1; cycle();
        chk("t4_owner", o_owner, 2);
        chk("t4_sw", o_sw, 4'b0001);
        i_shift_tick = 1;
        repeat (11) cycle();
        chk("t4_pre_done", o_sweep_done, 0);
        cycle();
        chk("t4_done", o_sweep_done, 1);
        chk("t4_sw_end", o_sw, 4'b1001);

        // Reset mid-sweep, then restart from sel 0 / color 0.
        repeat (5) cycle();
        i_shift_tick = 0;
        chk("t6_sel", o_sw[2:1], 2);
        i_reset = 0; cycle();
        chk("t6_owner", o_owner, 0);
        chk("t6_sw", o_sw, 4'h0);
        i_reset = 1; cycle();
        chk("t6_restart", o_sw, 4'b0001);

        // VIO beats AUTO; dropping VIO waits for a tick, enters AUTO at sel 0.
        i_reset = 0; i_vio_req = 1; i_vio_sw = 4'h5; cycle();
        i_reset = 1; cycle();
        chk("t5_owner", o_owner, 1);
        i_vio_req = 0; cycle();
        chk("t5_pend", o_pending, 1);
        cycle();
        i_shift_tick = 1; cycle(); i_shift_tick = 0;
        chk("t5_auto", o_owner, 2);
        chk("t5_sw", o_sw, 4'b0001);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            i_reset      = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 15) == 0) i_vio_req = !i_vio_req;
            if ($urandom_range(0, 11) == 0) i_auto = !i_auto;
            if ($urandom_range(0, 7) == 0)  i_sw = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  i_vio_sw = 4'($urandom);
            i_shift_tick = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
